// File: rtl/relu_ctrl_pkg.sv
// relu_ctrl_pkg: shared lane/top state types, widths and the ReLU clamp helper
// used by the ReLU pass sequencer and its per-lane FSMs.
package relu_ctrl_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int LANE_IDX_W = ADDR_W_DEF + 1;

    typedef enum logic [2:0] {
        L_IDLE,
        L_RD,
        L_WAIT,
        L_WR,
        L_DONE
    } lane_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } top_state_t;

    // Returns {clamped, result}; any set sign bit (including -0) maps to +0.
    function automatic logic [DATA_W_DEF:0] relu_f(
        input logic [DATA_W_DEF-1:0] d
    );
        logic neg;
        neg = d[DATA_W_DEF-1];
        return {neg, (neg ? {DATA_W_DEF{1'b0}} : d)};
    endfunction

endpackage

// File: rtl/relu_lane_fsm.sv
// relu_lane_fsm: one SRAM request lane; reads element i, clamps it, writes it
// back to dst, then steps i by M.
// Ports: launch/clear from the top FSM, latched src/dst/len, one request
// stream (req_v/req_we/req_addr/req_wdata/req_ready), one response stream
// (rsp_v/rsp_data), clamp event pulse and lane_done status.
module relu_lane_fsm
    import relu_ctrl_pkg::*;
#(
    parameter int M      = 8,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int Data_W = DATA_W_DEF,
    parameter int K      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  logic              clear,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    input  logic              req_ready,
    input  logic              rsp_v,
    input  logic [Data_W-1:0] rsp_data,
    output logic              req_v,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [Data_W-1:0] req_wdata,
    output logic              clamp,
    output logic              lane_done
);

    lane_state_t             state_q;
    lane_state_t             state_d;
    logic [LANE_IDX_W-1:0]   idx_q;
    logic [LANE_IDX_W-1:0]   idx_inc;
    logic [Data_W-1:0]       wdata_q;
    logic [DATA_W_DEF:0]     rf;

    assign idx_inc   = idx_q + LANE_IDX_W'(M);
    assign rf        = relu_f(rsp_data);
    assign req_wdata = wdata_q;
    assign lane_done = (state_q == L_DONE);

    always_comb begin
        state_d  = state_q;
        req_v    = 1'b0;
        req_we   = 1'b0;
        req_addr = '0;
        clamp    = 1'b0;
        unique case (state_q)
            L_IDLE: begin
                if (launch)
                    state_d = (LANE_IDX_W'(K) < len) ? L_RD : L_DONE;
            end
            L_RD: begin
                req_v    = 1'b1;
                req_addr = src_base + idx_q[ADDR_W-1:0];
                if (req_ready)
                    state_d = L_WAIT;
            end
            L_WAIT: begin
                if (rsp_v) begin
                    clamp   = rf[DATA_W_DEF];
                    state_d = L_WR;
                end
            end
            L_WR: begin
                req_v    = 1'b1;
                req_we   = 1'b1;
                req_addr = dst_base + idx_q[ADDR_W-1:0];
                if (req_ready)
                    state_d = (idx_inc < len) ? L_RD : L_DONE;
            end
            L_DONE: begin
                if (clear)
                    state_d = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= L_IDLE;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch)
                idx_q <= LANE_IDX_W'(K);
            else if (state_q == L_WR && req_ready)
                idx_q <= idx_inc;
            if (state_q == L_WAIT && rsp_v)
                wdata_q <= rf[Data_W-1:0];
        end
    end

endmodule

// File: rtl/relu_pass_ctrl.sv
// relu_pass_ctrl: runs one ReLU pass over a region of the banked scratch SRAM
// using M independent lanes; element i is handled by lane i mod M.
// Ports: start/src_base/dst_base/len command, busy/done/neg_cnt status,
// packed per-lane request bus (req_v, req_we, Req_addr, Req_wData, req_ready)
// and response bus (rsp_v, Rsp_rData).
module relu_pass_ctrl
    import relu_ctrl_pkg::*;
#(
    parameter int M      = 8,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int Data_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     src_base,
    input  logic [ADDR_W-1:0]     dst_base,
    input  logic [ADDR_W:0]       len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       neg_cnt,
    output logic [M-1:0]          req_v,
    output logic [M-1:0]          req_we,
    output logic [M*ADDR_W-1:0]   Req_addr,
    output logic [M*Data_W-1:0]   Req_wData,
    input  logic [M-1:0]          req_ready,
    input  logic [M*Data_W-1:0]   Rsp_rData,
    input  logic [M-1:0]          rsp_v
);

    localparam logic [ADDR_W+1:0] NEG_MAX = (ADDR_W+2)'(1) << ADDR_W;

    top_state_t          top_q;
    top_state_t          top_d;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     len_eff;
    logic                launch;
    logic                clear;
    logic [M-1:0]        clamp;
    logic [M-1:0]        lane_done;
    logic [ADDR_W+1:0]   neg_sum;

    assign launch = (top_q == IDLE) && start;
    assign clear  = (top_q == FIN);
    assign busy   = (top_q != IDLE);
    assign done   = (top_q == FIN);

    // Lanes decide L_RD vs L_DONE on the launch edge, before len_q is loaded.
    assign len_eff = (top_q == IDLE) ? len : len_q;

    always_comb begin
        top_d = top_q;
        unique case (top_q)
            IDLE:    if (start) top_d = RUN;
            RUN:     if (&lane_done) top_d = FIN;
            FIN:     top_d = IDLE;
            default: top_d = IDLE;
        endcase
    end

    always_comb begin
        neg_sum = {1'b0, neg_cnt};
        for (int k = 0; k < M; k++)
            neg_sum = neg_sum + (ADDR_W+2)'(clamp[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            neg_cnt <= '0;
        end else begin
            top_q <= top_d;
            if (launch) begin
                src_q   <= src_base;
                dst_q   <= dst_base;
                len_q   <= len;
                neg_cnt <= '0;
            end else if (neg_sum > NEG_MAX) begin
                neg_cnt <= NEG_MAX[ADDR_W:0];
            end else begin
                neg_cnt <= neg_sum[ADDR_W:0];
            end
        end
    end

    for (genvar k = 0; k < M; k++) begin : g_lane
        relu_lane_fsm #(
            .M      (M),
            .ADDR_W (ADDR_W),
            .Data_W (Data_W),
            .K      (k)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .launch    (launch),
            .clear     (clear),
            .src_base  (src_q),
            .dst_base  (dst_q),
            .len       (len_eff),
            .req_ready (req_ready[k]),
            .rsp_v     (rsp_v[k]),
            .rsp_data  (Rsp_rData[k*Data_W +: Data_W]),
            .req_v     (req_v[k]),
            .req_we    (req_we[k]),
            .req_addr  (Req_addr[k*ADDR_W +: ADDR_W]),
            .req_wdata (Req_wData[k*Data_W +: Data_W]),
            .clamp     (clamp[k]),
            .lane_done (lane_done[k])
        );
    end

endmodule

// File: tb/tb_relu_pass_ctrl.sv
// tb_relu_pass_ctrl: scoreboard bench for relu_pass_ctrl with a banked SRAM
// model that can make lanes 0 and 1 contend for one bank.
module tb_relu_pass_ctrl;

    localparam int M  = 8;
    localparam int AW = 12;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     src_base = '0;
    logic [AW-1:0]     dst_base = '0;
    logic [AW:0]       len = '0;
    logic              busy;
    logic              done;
    logic [AW:0]       neg_cnt;
    logic [M-1:0]      req_v;
    logic [M-1:0]      req_we;
    logic [M*AW-1:0]   Req_addr;
    logic [M*DW-1:0]   Req_wData;
    logic [M-1:0]      req_ready;
    logic [M*DW-1:0]   Rsp_rData = '0;
    logic [M-1:0]      rsp_v = '0;

    always #5 clk = ~clk;

    relu_pass_ctrl #(.M(M), .ADDR_W(AW), .Data_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .neg_cnt   (neg_cnt),
        .req_v     (req_v),
        .req_we    (req_we),
        .Req_addr  (Req_addr),
        .Req_wData (Req_wData),
        .req_ready (req_ready),
        .Rsp_rData (Rsp_rData),
        .rsp_v     (rsp_v)
    );

    // SRAM model
    logic [DW-1:0] mem [0:4095];
    logic          contend = 1'b0;
    logic          rr = 1'b0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [DW-1:0] pl_d = '0;

    always_comb begin
        req_ready = req_v;
        if (contend && req_v[0] && req_v[1]) begin
            req_ready[0] = ~rr;
            req_ready[1] = rr;
        end
    end

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_a] <= pl_d;
        if (contend && req_v[0] && req_v[1])
            rr <= ~rr;
        for (int k = 0; k < M; k++) begin
            if (req_v[k] && req_ready[k]) begin
                if (req_we[k])
                    mem[Req_addr[k*AW +: AW]] <= Req_wData[k*DW +: DW];
                else
                    Rsp_rData[k*DW +: DW] <= mem[Req_addr[k*AW +: AW]];
            end
        end
        rsp_v <= req_v & req_ready & ~req_we;
    end

    // Scoreboard
    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_wr [int];
    bit            exp_rd [int];
    logic [AW:0]   done_q [$];
    int            lane_wr [M];
    int            req_cycles = 0;
    int            cur_src = 0;
    int            cur_dst = 0;
    bit            chk_en = 1'b1;
    bit            hold_p [M];
    logic [AW+DW:0] hold_f [M];

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (|req_v)
            req_cycles++;
        for (int k = 0; k < M; k++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            a  = Req_addr[k*AW +: AW];
            wd = Req_wData[k*DW +: DW];
            if (!rst && chk_en) begin
                if (hold_p[k])
                    check($sformatf("hold_stable[%0d]", k),
                          {req_v[k], req_we[k], a, wd}, {1'b1, hold_f[k]});
                hold_p[k] = req_v[k] && !req_ready[k];
                hold_f[k] = {req_we[k], a, wd};
                if (req_v[k] && req_ready[k]) begin
                    if (req_we[k]) begin
                        check($sformatf("wr_lane[%0d]", k),
                              ((int'(a) - cur_dst) & 4095) % M, k);
                        if (exp_wr.exists(int'(a))) begin
                            check($sformatf("wr_data@%0h", a), wd, exp_wr[int'(a)]);
                            exp_wr.delete(int'(a));
                        end else begin
                            check($sformatf("wr_addr_expected@%0h", a), 0, 1);
                        end
                        lane_wr[k]++;
                    end else begin
                        check($sformatf("rd_lane[%0d]", k),
                              ((int'(a) - cur_src) & 4095) % M, k);
                        check($sformatf("rd_addr@%0h", a),
                              exp_rd.exists(int'(a)), 1);
                    end
                end
            end else begin
                hold_p[k] = 1'b0;
            end
        end
        if (done) begin
            if (done_q.size() == 0)
                check("done_expected", 1, 0);
            else
                check("neg_cnt", neg_cnt, done_q.pop_front());
        end
    end

    // Stimulus
    logic [DW-1:0] din  [0:31];
    logic [DW-1:0] dout [0:31];

    task automatic poke(input int a, input logic [DW-1:0] d);
        pl_en = 1'b1;
        pl_a  = AW'(a);
        pl_d  = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic pulse_start(input int s, input int d, input int n);
        src_base = AW'(s);
        dst_base = AW'(d);
        len      = (AW+1)'(n);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_pass(input int s, input int d, input int n,
                            input int neg, input string nm);
        bit seen;
        exp_wr.delete();
        exp_rd.delete();
        for (int k = 0; k < M; k++) lane_wr[k] = 0;
        for (int j = 0; j < n; j++) begin
            poke((s + j) & 4095, din[j]);
            exp_rd[(s + j) & 4095] = 1'b1;
            exp_wr[(d + j) & 4095] = dout[j];
        end
        cur_src = s;
        cur_dst = d;
        done_q.push_back((AW+1)'(neg));
        pulse_start(s, d, n);
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        check({nm, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({nm, "_busy_drop"}, busy, 0);
        check({nm, "_all_writes"}, exp_wr.num(), 0);
        for (int j = 0; j < n; j++)
            check($sformatf("%s_img[%0d]", nm, j), mem[(d + j) & 4095], dout[j]);
    endtask

    initial begin
        for (int k = 0; k < M; k++) hold_p[k] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_neg_cnt", neg_cnt, 0);
        check("rst_req_v", req_v, 0);
        check("rst_req_we", req_we, 0);
        check("rst_addr", Req_addr, 0);
        check("rst_wdata", Req_wData, 0);
        #1 rst = 1'b0;

        // alternating +1.0 / -1.0
        for (int j = 0; j < 8; j++) begin
            din[j]  = j[0] ? 16'hBC00 : 16'h3C00;
            dout[j] = j[0] ? 16'h0000 : 16'h3C00;
        end
        run_pass('h000, 'h100, 8, 4, "alt");

        // empty pass
        done_q.push_back('0);
        req_cycles = 0;
        pulse_start('h000, 'h100, 0);
        check("len0_busy", busy, 1);
        check("len0_done_early", done, 0);
        @(posedge clk);
        #1 check("len0_done_t2", done, 1);
        @(posedge clk);
        #1 check("len0_busy_drop", busy, 0);
        check("len0_no_req", req_cycles, 0);
        check("len0_neg_cnt", neg_cnt, 0);

        // in place, len 20
        for (int j = 0; j < 20; j++) begin
            din[j]  = (j % 3 == 0) ? 16'h8000 | 16'(j) : 16'h0100 | 16'(j);
            dout[j] = (j % 3 == 0) ? 16'h0000 : din[j];
        end
        run_pass('h040, 'h040, 20, 7, "inplace");
        for (int k = 0; k < M; k++)
            check($sformatf("inplace_lane_cnt[%0d]", k), lane_wr[k], (k < 4) ? 3 : 2);

        // lanes 0/1 contend on one bank
        contend = 1'b1;
        for (int j = 0; j < 16; j++) begin
            din[j]  = j[0] ? 16'hF000 | 16'(j) : 16'h0A00 | 16'(j);
            dout[j] = j[0] ? 16'h0000 : din[j];
        end
        run_pass('h208, 'h308, 16, 8, "contend");
        contend = 1'b0;

        // address wrap with -0
        din[0] = 16'h8000; dout[0] = 16'h0000;
        din[1] = 16'h1234; dout[1] = 16'h1234;
        din[2] = 16'hFFFF; dout[2] = 16'h0000;
        din[3] = 16'h7FFF; dout[3] = 16'h7FFF;
        run_pass('hFFE, 'h010, 4, 2, "wrap");

        // reset mid-pass
        chk_en = 1'b0;
        pulse_start('h400, 'h500, 16);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_req_v", req_v, 0);
        check("abort_done", done, 0);
        repeat (4) @(posedge clk);
        #1 check("abort_idle", busy, 0);
        chk_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            din[j]  = j[0] ? 16'h3C00 : 16'hC400;
            dout[j] = j[0] ? 16'h3C00 : 16'h0000;
        end
        run_pass('h000, 'h180, 8, 4, "post_abort");

        repeat (3) @(posedge clk);
        check("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
